sparse_chunk_writer: RTL and testbench

SPARSE_CHUNK_WRITER -- requirements
Module: sparse_chunk_writer

---
 rtl/sparse_chunk_writer.sv | 134 +++++++++++++
 tb/tb_sparse_chunk_writer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sparse_chunk_writer.sv
// sparse_chunk_writer: compresses dense beats into a sparse map plus packed nonzero bytes, then sends a chunk per credit.
// Define SPARSE_WRITER_THRESH_EN to add thresh_i; bytes <= thresh_i then count as zero.
module sparse_chunk_writer #(
    parameter int MEM_SIZE = 128,
    parameter int BUS_SIZE = 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
`ifdef SPARSE_WRITER_THRESH_EN
    input  logic [7:0]                            thresh_i,
`endif
    input  logic [BUS_SIZE*8-1:0]                 dense_dat_i,
    input  logic                                  dense_valid_i,
    output logic                                  dense_ready_o,
    output logic [BUS_SIZE-1:0]                   sparsemap_o,
    output logic [BUS_SIZE*8-1:0]                 nonzero_data_o,
    output logic                                  wr_valid_o,
    output logic [$clog2(MEM_SIZE/BUS_SIZE)-1:0]  wr_count_o,
    output logic                                  wr_sel_o,
    input  logic                                  chunk_end_i,
    output logic [$clog2(MEM_SIZE):0]             nz_count_o
);
    localparam int NB = MEM_SIZE / BUS_SIZE;
    localparam int CW = $clog2(NB);
    localparam int PW = $clog2(MEM_SIZE) + 1;

    typedef enum logic [1:0] {COLLECT, WAIT_CRED, SEND} state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d;
    logic [1:0]            credit, credit_d;
    logic [PW-1:0]         nz_ptr, nz_ptr_d;
    logic [MEM_SIZE-1:0]   map, map_d;
    logic [MEM_SIZE*8-1:0] store, store_d;
    logic [BUS_SIZE-1:0]   flags;
    logic [7:0]            thr;
    logic                  accept, first_send, last_send, last_beat;
    int                    p;

`ifdef SPARSE_WRITER_THRESH_EN
    assign thr = thresh_i;
`else
    assign thr = 8'd0;
`endif

    assign accept     = state == COLLECT && dense_valid_i;
    assign last_beat  = cnt == CW'(NB - 1);
    assign first_send = state == SEND && cnt == '0;
    assign last_send  = state == SEND && last_beat;

    always_comb begin
        flags = '0;
        for (int i = 0; i < BUS_SIZE; i++)
            flags[i] = dense_data_byte(i) > thr;
    end

    function automatic logic [7:0] dense_data_byte(input int i);
        return dense_dat_i[i*8 +: 8];
    endfunction

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        if (state == COLLECT) begin
            if (accept) begin
                cnt_d = last_beat ? '0 : cnt + CW'(1);
                if (last_beat)
                    state_d = credit != 2'd0 ? SEND : WAIT_CRED;
            end
        end else if (state == WAIT_CRED) begin
            if (credit != 2'd0)
                state_d = SEND;
        end else if (state == SEND) begin
            cnt_d   = last_beat ? '0 : cnt + CW'(1);
            state_d = last_beat ? COLLECT : SEND;
        end
    end

    // A consumer pulse on the first send cycle cancels that send's credit use.
    always_comb begin
        credit_d = first_send ? (chunk_end_i ? credit : credit - 2'd1)
                              : (chunk_end_i && credit != 2'd2 ? credit + 2'd1 : credit);
    end

    // Store is cleared per chunk, so bytes past nz_ptr are already zero.
    always_comb begin
        map_d    = map;
        store_d  = store;
        nz_ptr_d = nz_ptr;
        p        = int'(nz_ptr);
        if (last_send) begin
            map_d    = '0;
            store_d  = '0;
            nz_ptr_d = '0;
        end else if (accept) begin
            map_d[cnt*BUS_SIZE +: BUS_SIZE] = flags;
            for (int i = 0; i < BUS_SIZE; i++) begin
                if (flags[i]) begin
                    store_d[p*8 +: 8] = dense_dat_i[i*8 +: 8];
                    p++;
                end
            end
            nz_ptr_d = PW'(p);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= COLLECT;
            cnt        <= '0;
            credit     <= 2'd2;
            nz_ptr     <= '0;
            map        <= '0;
            store      <= '0;
            wr_sel_o   <= 1'b0;
            nz_count_o <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            credit     <= credit_d;
            nz_ptr     <= nz_ptr_d;
            map        <= map_d;
            store      <= store_d;
            wr_sel_o   <= last_send ? ~wr_sel_o : wr_sel_o;
            nz_count_o <= first_send ? nz_ptr : nz_count_o;
        end
    end

    assign dense_ready_o  = state == COLLECT && !rst_i;
    assign wr_valid_o     = state == SEND;
    assign wr_count_o     = wr_valid_o ? cnt : '0;
    assign sparsemap_o    = wr_valid_o ? map[cnt*BUS_SIZE +: BUS_SIZE] : '0;
    assign nonzero_data_o = wr_valid_o ? store[cnt*BUS_SIZE*8 +: BUS_SIZE*8] : '0;
endmodule

// File: tb/tb_sparse_chunk_writer.sv
// tb_sparse_chunk_writer: directed + random chunks checked against a byte-level reference model.
module tb_sparse_chunk_writer;
    localparam int MEM_SIZE = 128;
    localparam int BUS_SIZE = 8;
    localparam int NB = MEM_SIZE / BUS_SIZE;

    logic                  clk_i = 1'b0;
    logic                  rst_i = 1'b1;
    logic [BUS_SIZE*8-1:0] dense_dat_i = '0;
    logic                  dense_valid_i = 1'b0;
    logic                  dense_ready_o;
    logic [BUS_SIZE-1:0]   sparsemap_o;
    logic [BUS_SIZE*8-1:0] nonzero_data_o;
    logic                  wr_valid_o;
    logic [3:0]            wr_count_o;
    logic                  wr_sel_o;
    logic                  chunk_end_i = 1'b0;
    logic [7:0]            nz_count_o;
    logic [7:0]            thr = 8'd0;

    int   total = 0;
    int   bad = 0;
    int   credit_m = 2;
    logic sel_m = 1'b0;
    logic [7:0] cb [MEM_SIZE];

    always #5 clk_i = ~clk_i;

    sparse_chunk_writer #(.MEM_SIZE(MEM_SIZE), .BUS_SIZE(BUS_SIZE)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
`ifdef SPARSE_WRITER_THRESH_EN
        .thresh_i(thr),
`endif
        .dense_dat_i(dense_dat_i),
        .dense_valid_i(dense_valid_i),
        .dense_ready_o(dense_ready_o),
        .sparsemap_o(sparsemap_o),
        .nonzero_data_o(nonzero_data_o),
        .wr_valid_o(wr_valid_o),
        .wr_count_o(wr_count_o),
        .wr_sel_o(wr_sel_o),
        .chunk_end_i(chunk_end_i),
        .nz_count_o(nz_count_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < MEM_SIZE; i++)
            cb[i] = $urandom_range(0, 1) != 0 ? 8'($urandom_range(1, 255)) : 8'h00;
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < MEM_SIZE; i++) cb[i] = v;
    endtask

    task automatic pulse();
        chunk_end_i = 1'b1;
        @(negedge clk_i);
        chunk_end_i = 1'b0;
        credit_m = credit_m < 2 ? credit_m + 1 : 2;
    endtask

    task automatic push_chunk();
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < BUS_SIZE; j++) dense_dat_i[j*8 +: 8] = cb[b*BUS_SIZE + j];
            dense_valid_i = 1'b1;
            for (int n = 0; n < 100 && !dense_ready_o; n++) @(negedge clk_i);
            chk("in_ready", 64'(dense_ready_o), 64'd1);
            @(negedge clk_i);
        end
        dense_valid_i = 1'b0;
        dense_dat_i = '0;
    endtask

    task automatic check_send(input bit pulse_first, input int abort);
        logic [7:0] pk [MEM_SIZE];
        logic [BUS_SIZE-1:0] em;
        logic [BUS_SIZE*8-1:0] ed;
        int np;
        np = 0;
        for (int i = 0; i < MEM_SIZE; i++) pk[i] = 8'h00;
        for (int i = 0; i < MEM_SIZE; i++) if (cb[i] > thr) begin pk[np] = cb[i]; np++; end
        for (int n = 0; n < 100 && !wr_valid_o; n++) @(negedge clk_i);
        chk("send_start", 64'(wr_valid_o), 64'd1);
        if (pulse_first) chunk_end_i = 1'b1;
        else credit_m--;
        for (int b = 0; b < NB; b++) begin
            if (b == 1) chunk_end_i = 1'b0;
            for (int j = 0; j < BUS_SIZE; j++) begin
                em[j] = cb[b*BUS_SIZE + j] > thr;
                ed[j*8 +: 8] = pk[b*BUS_SIZE + j];
            end
            chk("wr_valid", 64'(wr_valid_o), 64'd1);
            chk("wr_count", 64'(wr_count_o), 64'(b));
            chk("wr_sel", 64'(wr_sel_o), 64'(sel_m));
            chk("sparsemap", 64'(sparsemap_o), 64'(em));
            chk("nonzero_data", 64'(nonzero_data_o), 64'(ed));
            if (b == abort) begin
                rst_i = 1'b1;
                #1;
                chk("rst_valid", 64'(wr_valid_o), 64'd0);
                chk("rst_count", 64'(wr_count_o), 64'd0);
                chk("rst_sel", 64'(wr_sel_o), 64'd0);
                chk("rst_ready", 64'(dense_ready_o), 64'd0);
                chk("rst_nz", 64'(nz_count_o), 64'd0);
                @(negedge clk_i);
                rst_i = 1'b0;
                @(negedge clk_i);
                chk("rel_ready", 64'(dense_ready_o), 64'd1);
                credit_m = 2;
                sel_m = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        chunk_end_i = 1'b0;
        sel_m = ~sel_m;
        chk("end_valid", 64'(wr_valid_o), 64'd0);
        chk("nz_count", 64'(nz_count_o), 64'(np));
        chk("end_sel", 64'(wr_sel_o), 64'(sel_m));
        chk("idle_count", 64'(wr_count_o), 64'd0);
        chk("idle_map", 64'(sparsemap_o), 64'd0);
        chk("idle_data", 64'(nonzero_data_o), 64'd0);
    endtask

    task automatic do_chunk(input bit pulse_first, input int abort);
        push_chunk();
        if (credit_m == 0) begin
            repeat (4) begin
                chk("wait_valid", 64'(wr_valid_o), 64'd0);
                chk("wait_ready", 64'(dense_ready_o), 64'd0);
                @(negedge clk_i);
            end
            pulse();
        end else begin
            chk("latency", 64'(wr_valid_o), 64'd1);
        end
        check_send(pulse_first, abort);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        chk("reset_ready", 64'(dense_ready_o), 64'd0);
        chk("reset_valid", 64'(wr_valid_o), 64'd0);
        chk("reset_count", 64'(wr_count_o), 64'd0);
        chk("reset_sel", 64'(wr_sel_o), 64'd0);
        chk("reset_nz", 64'(nz_count_o), 64'd0);
        chk("reset_map", 64'(sparsemap_o), 64'd0);
        chk("reset_data", 64'(nonzero_data_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("release_ready", 64'(dense_ready_o), 64'd1);
        fill_const(8'h11);
        do_chunk(1'b0, -1);
        chk("all11_nz", 64'(nz_count_o), 64'd128);
        fill_const(8'h00);
        cb[3] = 8'h5a;
        do_chunk(1'b0, -1);
        chk("single_nz", 64'(nz_count_o), 64'd1);
        fill_rand();
        do_chunk(1'b0, -1);
        repeat (3) begin
            pulse();
            @(negedge clk_i);
        end
        fill_rand();
        do_chunk(1'b0, -1);
        fill_rand();
        do_chunk(1'b0, -1);
        fill_rand();
        do_chunk(1'b1, -1);
        fill_rand();
        do_chunk(1'b0, -1);
        fill_rand();
        do_chunk(1'b0, 7);
        fill_rand();
        do_chunk(1'b0, -1);
        fill_rand();
        do_chunk(1'b0, -1);
`ifdef SPARSE_WRITER_THRESH_EN
        thr = 8'h20;
        fill_const(8'h00);
        cb[0] = 8'h20;
        cb[1] = 8'h21;
        do_chunk(1'b0, -1);
        chk("thresh_nz", 64'(nz_count_o), 64'd1);
        thr = 8'h00;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not end, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
